// File: rtl/qdma_stm_lpbk_arb_pkg.sv
// Shared types and the round-robin pick helper for the ST loopback arbiter.
// The beat struct width is fixed here; the arbiter and interface parameters default to it.
package qdma_stm_lpbk_pkg;

  localparam int unsigned STM_DATA_W  = 512;
  localparam int unsigned STM_TDEST_W = 16;
  localparam int unsigned MAX_PORTS   = 8;
  localparam int unsigned PORT_IDX_W  = 3;

  typedef struct packed {
    logic [STM_DATA_W-1:0]  tdata;
    logic                   tuser;
    logic [STM_TDEST_W-1:0] tdest;
    logic                   tlast;
  } stm_beat_t;

  typedef enum logic {IDLE, BUSY} arb_state_e;

  // First set bit of req at or after ptr, wrapping within the n live ports.
  function automatic logic [PORT_IDX_W-1:0] rr_pick(input logic [MAX_PORTS-1:0]  req,
                                                    input logic [PORT_IDX_W-1:0] ptr,
                                                    input int unsigned           n);
    logic [PORT_IDX_W-1:0] pick;
    logic [PORT_IDX_W-1:0] idx3;
    logic                  found;
    int unsigned           idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_PORTS; i++) begin
      idx  = (32'(ptr) + i) % n;
      idx3 = idx[PORT_IDX_W-1:0];
      if (!found && (i < n) && req[idx3]) begin
        pick  = idx3;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/qdma_stm_lpbk_arb_if.sv
// AXI-Stream bundle for the loopback arbiter: NUM_PORTS sources in, one merged stream out.
interface qdma_stm_lpbk_arb_if
  import qdma_stm_lpbk_pkg::*;
#(
  parameter int unsigned NUM_PORTS      = 4,
  parameter int unsigned MAX_DATA_WIDTH = STM_DATA_W,
  parameter int unsigned TDEST_BITS     = STM_TDEST_W
);

  logic [NUM_PORTS*MAX_DATA_WIDTH-1:0] in_axis_tdata;
  logic [NUM_PORTS*TDEST_BITS-1:0]     in_axis_tdest;
  logic [NUM_PORTS-1:0]                in_axis_tuser;
  logic [NUM_PORTS-1:0]                in_axis_tlast;
  logic [NUM_PORTS-1:0]                in_axis_tvalid;
  logic [NUM_PORTS-1:0]                in_axis_tready;

  logic [MAX_DATA_WIDTH-1:0]           out_axis_tdata;
  logic [TDEST_BITS-1:0]               out_axis_tdest;
  logic                                out_axis_tuser;
  logic                                out_axis_tlast;
  logic                                out_axis_tvalid;
  logic                                out_axis_tready;

  modport slave (
    input  in_axis_tdata, in_axis_tdest, in_axis_tuser, in_axis_tlast, in_axis_tvalid,
    output in_axis_tready,
    output out_axis_tdata, out_axis_tdest, out_axis_tuser, out_axis_tlast, out_axis_tvalid,
    input  out_axis_tready
  );

  modport master (
    output in_axis_tdata, in_axis_tdest, in_axis_tuser, in_axis_tlast, in_axis_tvalid,
    input  in_axis_tready,
    input  out_axis_tdata, out_axis_tdest, out_axis_tuser, out_axis_tlast, out_axis_tvalid,
    output out_axis_tready
  );

endinterface

// File: rtl/qdma_stm_lpbk_arb_slice.sv
// Two-entry valid/ready register slice; in_rdy depends only on local occupancy.
module qdma_stm_lpbk_slice
  import qdma_stm_lpbk_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      in_vld,
  output logic      in_rdy,
  input  stm_beat_t in_data,
  output logic      out_vld,
  input  logic      out_rdy,
  output stm_beat_t out_data
);

  stm_beat_t  r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_cnt;

  logic w_push;
  logic w_pop;

  assign in_rdy   = (r_cnt != 2'd2);
  assign out_vld  = (r_cnt != 2'd0);
  assign out_data = r_mem[r_rd_ptr];
  assign w_push   = in_vld & in_rdy;
  assign w_pop    = out_vld & out_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

endmodule

// File: rtl/qdma_stm_lpbk_arb.sv
// Packet-atomic weighted round-robin arbiter merging H2C AXI-Stream sources into the
// ST loopback input, with per-port packet quota and a 2-entry output slice.
module qdma_stm_lpbk_arb
  import qdma_stm_lpbk_pkg::*;
#(
  parameter int unsigned NUM_PORTS      = 4,
  parameter int unsigned MAX_DATA_WIDTH = STM_DATA_W,
  parameter int unsigned TDEST_BITS     = STM_TDEST_W,
  parameter int unsigned QUOTA_BITS     = 4
)(
  input  logic                          clk,
  input  logic                          rst_n,
  qdma_stm_lpbk_arb_if.slave            axis,
  input  logic [NUM_PORTS-1:0]          cfg_port_en,
  input  logic [NUM_PORTS*QUOTA_BITS-1:0] cfg_quota,
  output logic                          stat_pkt_done,
  output logic [$clog2(NUM_PORTS)-1:0]  stat_pkt_port
);

  localparam int unsigned PW = $clog2(NUM_PORTS);

  arb_state_e            r_state;
  logic [PW-1:0]         r_grant;
  logic [PW-1:0]         r_rr_ptr;
  logic [QUOTA_BITS-1:0] r_quota_cnt;
  logic                  r_stat_done;
  logic [PW-1:0]         r_stat_port;

  logic [MAX_DATA_WIDTH-1:0] w_tdata [NUM_PORTS];
  logic [TDEST_BITS-1:0]     w_tdest [NUM_PORTS];
  logic [QUOTA_BITS-1:0]     w_quota [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign w_tdata[i] = axis.in_axis_tdata[i*MAX_DATA_WIDTH +: MAX_DATA_WIDTH];
    assign w_tdest[i] = axis.in_axis_tdest[i*TDEST_BITS +: TDEST_BITS];
    assign w_quota[i] = cfg_quota[i*QUOTA_BITS +: QUOTA_BITS];
  end

  logic                  w_busy;
  logic [NUM_PORTS-1:0]  w_req;
  logic [PW-1:0]         w_pick;
  logic                  w_slice_in_vld;
  logic                  w_slice_in_rdy;
  logic                  w_accept;
  logic                  w_g_last;
  logic [QUOTA_BITS-1:0] w_quota_lim;
  logic [QUOTA_BITS:0]   w_cnt_inc;
  logic                  w_stay;
  logic [PW-1:0]         w_ptr_next;
  logic [NUM_PORTS-1:0]  w_tready;
  stm_beat_t             w_beat_in;
  stm_beat_t             w_beat_out;

  assign w_busy         = (r_state == BUSY);
  assign w_req          = axis.in_axis_tvalid & cfg_port_en;
  assign w_pick         = PW'(rr_pick(MAX_PORTS'(w_req), PORT_IDX_W'(r_rr_ptr), NUM_PORTS));
  assign w_slice_in_vld = w_busy & axis.in_axis_tvalid[r_grant];
  assign w_accept       = w_slice_in_vld & w_slice_in_rdy;
  assign w_g_last       = axis.in_axis_tlast[r_grant];

  // A quota of zero behaves as one packet per grant.
  assign w_quota_lim = (w_quota[r_grant] == '0) ? QUOTA_BITS'(1) : w_quota[r_grant];
  assign w_cnt_inc   = {1'b0, r_quota_cnt} + (QUOTA_BITS+1)'(1);
  assign w_stay      = (w_cnt_inc < {1'b0, w_quota_lim}) && cfg_port_en[r_grant];
  assign w_ptr_next  = (r_grant == PW'(NUM_PORTS-1)) ? '0 : r_grant + PW'(1);

  always_comb begin
    w_tready = '0;
    if (w_busy) w_tready[r_grant] = w_slice_in_rdy;
  end
  assign axis.in_axis_tready = w_tready;

  always_comb begin
    w_beat_in       = '0;
    w_beat_in.tdata = w_tdata[r_grant];
    w_beat_in.tdest = w_tdest[r_grant];
    w_beat_in.tuser = axis.in_axis_tuser[r_grant];
    w_beat_in.tlast = w_g_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_quota_cnt <= '0;
      r_stat_done <= 1'b0;
      r_stat_port <= '0;
    end else begin
      r_stat_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|w_req) begin
            r_grant     <= w_pick;
            r_quota_cnt <= '0;
            r_state     <= BUSY;
          end
        end
        BUSY: begin
          if (w_accept && w_g_last) begin
            r_stat_done <= 1'b1;
            r_stat_port <= r_grant;
            r_quota_cnt <= (&r_quota_cnt) ? r_quota_cnt : r_quota_cnt + QUOTA_BITS'(1);
            if (!w_stay) begin
              r_rr_ptr <= w_ptr_next;
              r_state  <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign stat_pkt_done = r_stat_done;
  assign stat_pkt_port = r_stat_port;

  qdma_stm_lpbk_slice u_slice (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (w_slice_in_vld),
    .in_rdy   (w_slice_in_rdy),
    .in_data  (w_beat_in),
    .out_vld  (axis.out_axis_tvalid),
    .out_rdy  (axis.out_axis_tready),
    .out_data (w_beat_out)
  );

  assign axis.out_axis_tdata = w_beat_out.tdata;
  assign axis.out_axis_tdest = w_beat_out.tdest;
  assign axis.out_axis_tuser = w_beat_out.tuser;
  assign axis.out_axis_tlast = w_beat_out.tlast;

endmodule

// File: tb/tb_qdma_stm_lpbk_arb.sv
// Scoreboard bench for the loopback arbiter: per-port source queues, expected-beat queue,
// slice occupancy model and stat pulse tracking.
module tb_qdma_stm_lpbk_arb;
  import qdma_stm_lpbk_pkg::*;

  localparam int NP = 4;
  localparam int DW = 512;
  localparam int TW = 16;
  localparam int QB = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NP-1:0]   cfg_port_en = '1;
  logic [NP*QB-1:0] cfg_quota = {NP{4'd1}};
  logic            stat_pkt_done;
  logic [1:0]      stat_pkt_port;

  qdma_stm_lpbk_arb_if #(.NUM_PORTS(NP), .MAX_DATA_WIDTH(DW), .TDEST_BITS(TW)) axis ();

  qdma_stm_lpbk_arb #(
    .NUM_PORTS      (NP),
    .MAX_DATA_WIDTH (DW),
    .TDEST_BITS     (TW),
    .QUOTA_BITS     (QB)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .axis          (axis),
    .cfg_port_en   (cfg_port_en),
    .cfg_quota     (cfg_quota),
    .stat_pkt_done (stat_pkt_done),
    .stat_pkt_port (stat_pkt_port)
  );

  always #5 clk = ~clk;

  int        checks = 0;
  int        errors = 0;
  stm_beat_t src_q [NP][$];
  stm_beat_t exp_q [$];
  int        exp_stat_q [$];
  int        occ = 0;
  int        cyc = 0;
  int        last_tl_cyc = -1;
  int        acc_cnt [NP];
  logic [NP-1:0] in_pkt = '0;
  logic      pend_stat = 1'b0;
  bit        gap_chk = 1'b0;
  bit        rdy_mode = 1'b0;
  logic [3:0] rdy_pat = 4'b1001;

  // Drive at negedge, decide handshakes at negedge+1 (stable until the next posedge).
  always @(negedge clk) begin
    stm_beat_t b;
    stm_beat_t e;
    stm_beat_t got;
    int        in_acc;
    int        es;
    logic      out_acc;
    for (int p = 0; p < NP; p++) begin
      if (src_q[p].size() > 0) begin
        b = src_q[p][0];
        axis.in_axis_tdata[p*DW +: DW] = b.tdata;
        axis.in_axis_tdest[p*TW +: TW] = b.tdest;
        axis.in_axis_tuser[p]          = b.tuser;
        axis.in_axis_tlast[p]          = b.tlast;
        axis.in_axis_tvalid[p]         = 1'b1;
      end else begin
        axis.in_axis_tvalid[p] = 1'b0;
      end
    end
    axis.out_axis_tready = rdy_mode ? rdy_pat[cyc % 4] : 1'b1;
    cyc++;
    #1;
    if (rst_n) begin
      checks++;
      if (stat_pkt_done !== pend_stat) begin
        errors++;
        $display("FAIL stat_pulse cyc=%0d got=%b exp=%b", cyc, stat_pkt_done, pend_stat);
      end
      if (stat_pkt_done === 1'b1) begin
        checks++;
        if (exp_stat_q.size() == 0) begin
          errors++;
          $display("FAIL stat_port unexpected pulse port=%0d", stat_pkt_port);
        end else begin
          es = exp_stat_q.pop_front();
          if (stat_pkt_port !== 2'(es)) begin
            errors++;
            $display("FAIL stat_port got=%0d exp=%0d", stat_pkt_port, es);
          end
        end
      end
      checks++;
      if (axis.out_axis_tvalid !== (occ != 0)) begin
        errors++;
        $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, axis.out_axis_tvalid, occ != 0);
      end
      if (occ == 2) begin
        checks++;
        if (axis.in_axis_tready !== '0) begin
          errors++;
          $display("FAIL tready_full got=%b exp=0000", axis.in_axis_tready);
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (in_pkt[p]) begin
          for (int q = 0; q < NP; q++) begin
            checks++;
            if (axis.in_axis_tready[q] !== ((q == p) ? (occ < 2) : 1'b0)) begin
              errors++;
              $display("FAIL atomic cyc=%0d grant=%0d port=%0d got=%b exp=%b", cyc, p, q,
                       axis.in_axis_tready[q], (q == p) ? (occ < 2) : 1'b0);
            end
          end
        end
      end
      in_acc    = 0;
      pend_stat = 1'b0;
      for (int p = 0; p < NP; p++) begin
        if (axis.in_axis_tvalid[p] && axis.in_axis_tready[p] === 1'b1) begin
          b = src_q[p].pop_front();
          in_acc++;
          acc_cnt[p]++;
          if (!in_pkt[p] && gap_chk && last_tl_cyc >= 0) begin
            checks++;
            if (cyc - last_tl_cyc != 2) begin
              errors++;
              $display("FAIL arb_gap port=%0d got=%0d exp=2", p, cyc - last_tl_cyc);
            end
          end
          in_pkt[p] = !b.tlast;
          if (b.tlast) begin
            pend_stat   = 1'b1;
            last_tl_cyc = cyc;
          end
        end
      end
      checks++;
      if (in_acc > 1) begin
        errors++;
        $display("FAIL one_accept got=%0d exp<=1", in_acc);
      end
      out_acc = axis.out_axis_tvalid & axis.out_axis_tready;
      if (out_acc) begin
        got.tdata = axis.out_axis_tdata;
        got.tdest = axis.out_axis_tdest;
        got.tuser = axis.out_axis_tuser;
        got.tlast = axis.out_axis_tlast;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_beat unexpected tag=%h", got.tdata[31:0]);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL out_beat got tag=%h dest=%h u=%b l=%b exp tag=%h dest=%h u=%b l=%b",
                     got.tdata[31:0], got.tdest, got.tuser, got.tlast,
                     e.tdata[31:0], e.tdest, e.tuser, e.tlast);
          end
        end
      end
      occ = occ + in_acc - (out_acc ? 1 : 0);
    end
  end

  task automatic flush();
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      acc_cnt[p] = 0;
    end
    exp_q.delete();
    exp_stat_q.delete();
    occ         = 0;
    in_pkt      = '0;
    pend_stat   = 1'b0;
    last_tl_cyc = -1;
    gap_chk     = 1'b0;
    rdy_mode    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    flush();
    cfg_port_en = '1;
    cfg_quota   = {NP{4'd1}};
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic add_pkt(input int p, input int id, input int n, input bit expect_out);
    stm_beat_t b;
    for (int k = 0; k < n; k++) begin
      for (int w = 0; w < DW / 32; w++) b.tdata[w*32 +: 32] = $urandom();
      b.tdata[31:0] = {8'(p), 8'(id), 8'(k), 8'hA5};
      b.tdest       = 16'(p * 256 + id);
      b.tuser       = (k == 0);
      b.tlast       = (k == n - 1);
      src_q[p].push_back(b);
      if (expect_out) exp_q.push_back(b);
    end
    if (expect_out) exp_stat_q.push_back(p);
  endtask

  task automatic wait_done(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && exp_stat_q.size() == 0 && occ == 0) break;
      @(negedge clk);
    end
    checks++;
    if (i >= budget) begin
      errors++;
      $display("FAIL %s timeout beats_left=%0d stats_left=%0d exp=0", name, exp_q.size(),
               exp_stat_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_acc(input int p, input int n, input int budget);
    int i;
    for (i = 0; i < budget && acc_cnt[p] < n; i++) @(negedge clk);
    checks++;
    if (acc_cnt[p] < n) begin
      errors++;
      $display("FAIL wait_acc port=%0d got=%0d exp=%0d", p, acc_cnt[p], n);
    end
  endtask

  task automatic test_reset();
    flush();
    repeat (3) @(negedge clk);
    #3;
    checks += 4;
    if (axis.out_axis_tvalid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got=%b exp=0", axis.out_axis_tvalid);
    end
    if (axis.in_axis_tready !== '0) begin
      errors++; $display("FAIL reset_tready got=%b exp=0000", axis.in_axis_tready);
    end
    if (stat_pkt_done !== 1'b0) begin
      errors++; $display("FAIL reset_stat_done got=%b exp=0", stat_pkt_done);
    end
    if (stat_pkt_port !== 2'd0) begin
      errors++; $display("FAIL reset_stat_port got=%0d exp=0", stat_pkt_port);
    end
    rst_n = 1'b1;
  endtask

  // Ports 0 and 2 alternate; port 0 quota of 0 behaves as 1.
  task automatic test_alternate();
    do_reset();
    cfg_quota = {4'd1, 4'd1, 4'd1, 4'd0};
    gap_chk   = 1'b1;
    add_pkt(0, 1, 3, 1'b1);
    add_pkt(2, 1, 3, 1'b1);
    add_pkt(0, 2, 3, 1'b1);
    add_pkt(2, 2, 3, 1'b1);
    wait_done("alternate", 200);
  endtask

  task automatic test_quota();
    do_reset();
    cfg_quota = {4'd1, 4'd1, 4'd3, 4'd1};
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) add_pkt(1, r * 3 + k, 1, 1'b1);
      add_pkt(3, r, 1, 1'b1);
    end
    wait_done("quota", 200);
  endtask

  task automatic test_atomic();
    do_reset();
    gap_chk = 1'b1;
    add_pkt(0, 7, 5, 1'b1);
    wait_acc(0, 2, 50);
    #2;
    add_pkt(1, 8, 2, 1'b1);
    wait_done("atomic", 200);
  endtask

  task automatic test_backpressure();
    do_reset();
    rdy_mode = 1'b1;
    add_pkt(0, 9, 8, 1'b1);
    wait_done("backpressure", 300);
  endtask

  task automatic test_port_disable();
    do_reset();
    cfg_quota = {4'd1, 4'd1, 4'd1, 4'd4};
    add_pkt(0, 10, 4, 1'b1);
    add_pkt(0, 11, 4, 1'b0);
    add_pkt(1, 12, 2, 1'b1);
    wait_acc(0, 2, 50);
    #2;
    cfg_port_en[0] = 1'b0;
    wait_done("port_disable", 200);
    repeat (20) @(negedge clk);
    #2;
    checks += 2;
    if (src_q[0].size() != 4) begin
      errors++; $display("FAIL no_regrant beats_left got=%0d exp=4", src_q[0].size());
    end
    if (axis.in_axis_tready !== '0) begin
      errors++; $display("FAIL no_regrant tready got=%b exp=0000", axis.in_axis_tready);
    end
  endtask

  task automatic test_reset_midpkt();
    do_reset();
    add_pkt(2, 13, 6, 1'b1);
    wait_acc(2, 3, 50);
    #3;
    rst_n = 1'b0;
    #1;
    checks += 2;
    if (axis.out_axis_tvalid !== 1'b0) begin
      errors++; $display("FAIL midrst_out_valid got=%b exp=0", axis.out_axis_tvalid);
    end
    if (axis.in_axis_tready !== '0) begin
      errors++; $display("FAIL midrst_tready got=%b exp=0000", axis.in_axis_tready);
    end
    flush();
    add_pkt(3, 14, 2, 1'b1);
    add_pkt(1, 15, 2, 1'b1);
    // Port 1 ahead of port 3 in the expected stream: rr_ptr restarts at 0.
    exp_q.delete();
    exp_stat_q.delete();
    for (int k = 0; k < 2; k++) exp_q.push_back(src_q[1][k]);
    for (int k = 0; k < 2; k++) exp_q.push_back(src_q[3][k]);
    exp_stat_q.push_back(1);
    exp_stat_q.push_back(3);
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b1;
    wait_done("reset_midpkt", 200);
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_quota();
    test_atomic();
    test_backpressure();
    test_port_disable();
    test_reset_midpkt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
